// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and defaults for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int DEFAULT_WIDTH      = 32;
    localparam int DEFAULT_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_D_XFER = 2'd1,
        ST_I_XFER = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_DATA  = 1'b0,
        GRANT_INSTR = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_port_arbiter_burst_counter.sv
// rtl/mem_port_arbiter_burst_counter.sv - wrap-around beat counter with clear, increment and last flag
module burst_counter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [$clog2(N)-1:0] count,
    output logic                 last
);

    localparam int CW = $clog2(N);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = last ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CW'(N - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates data accesses and instruction line refills onto one memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_req,
    input  logic [WIDTH-1:0]              i_addr,
    output logic                          i_rvalid,
    output logic [WIDTH-1:0]              i_rdata,
    output logic [$clog2(LINE_WORDS)-1:0] i_beat,
    output logic                          i_done,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [WIDTH-1:0]              d_addr,
    input  logic [WIDTH-1:0]              d_wdata,
    output logic [WIDTH-1:0]              d_rdata,
    output logic                          d_done,
    output logic                          mem_valid,
    output logic                          mem_we,
    output logic [WIDTH-1:0]              mem_addr,
    output logic [WIDTH-1:0]              mem_wdata,
    input  logic                          mem_ready,
    input  logic [WIDTH-1:0]              mem_rdata,
    output logic                          busy
);

    localparam int BW = $clog2(LINE_WORDS);

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic [WIDTH-1:0]  addr_q, addr_d;
    logic              we_q, we_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              mem_valid_q, mem_valid_d;
    logic              d_done_q, d_done_d;
    logic [WIDTH-1:0]  d_rdata_q, d_rdata_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic [WIDTH-1:0]  i_rdata_q, i_rdata_d;
    logic [BW-1:0]     i_beat_q, i_beat_d;
    logic              i_done_q, i_done_d;

    logic              d_elig, i_elig;
    logic [BW-1:0]     beat;
    logic              beat_last;
    logic              beat_inc;
    logic              beat_clr;

    assign beat_inc = (state_q == ST_I_XFER) && mem_ready;
    assign beat_clr = (state_q == ST_IDLE);

    burst_counter #(
        .N (LINE_WORDS)
    ) u_burst_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (beat_clr),
        .inc     (beat_inc),
        .count   (beat),
        .last    (beat_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A requester whose done pulse is showing has already been served this round.
    assign d_elig = d_req && !d_done_q;
    assign i_elig = i_req && !i_done_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (d_elig && (!i_elig || last_grant_q == GRANT_INSTR)) begin
                    state_d = ST_D_XFER;
                end else if (i_elig) begin
                    state_d = ST_I_XFER;
                end
            end
            ST_D_XFER: if (mem_ready) state_d = ST_IDLE;
            ST_I_XFER: if (mem_ready && beat_last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        if (state_q == ST_IDLE && state_d == ST_D_XFER) begin
            last_grant_d = GRANT_DATA;
            addr_d       = d_addr;
            we_d         = d_we;
            wdata_d      = d_wdata;
        end else if (state_q == ST_IDLE && state_d == ST_I_XFER) begin
            last_grant_d = GRANT_INSTR;
            addr_d       = i_addr;
            we_d         = 1'b0;
            wdata_d      = '0;
        end

        mem_valid_d = (state_d != ST_IDLE);
        d_done_d    = (state_q == ST_D_XFER) && mem_ready;
        d_rdata_d   = (d_done_d && !we_q) ? mem_rdata : d_rdata_q;
        i_rvalid_d  = beat_inc;
        i_rdata_d   = beat_inc ? mem_rdata : i_rdata_q;
        i_beat_d    = beat_inc ? beat : i_beat_q;
        i_done_d    = beat_inc && beat_last;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= GRANT_INSTR;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            mem_valid_q  <= 1'b0;
            d_done_q     <= 1'b0;
            d_rdata_q    <= '0;
            i_rvalid_q   <= 1'b0;
            i_rdata_q    <= '0;
            i_beat_q     <= '0;
            i_done_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            mem_valid_q  <= mem_valid_d;
            d_done_q     <= d_done_d;
            d_rdata_q    <= d_rdata_d;
            i_rvalid_q   <= i_rvalid_d;
            i_rdata_q    <= i_rdata_d;
            i_beat_q     <= i_beat_d;
            i_done_q     <= i_done_d;
        end
    end

    // Port fields decode from latched registers only, so they cannot move during a stall.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            ST_D_XFER: begin
                mem_addr  = addr_q;
                mem_we    = we_q;
                mem_wdata = wdata_q;
            end
            ST_I_XFER: begin
                mem_addr = addr_q + {{(WIDTH-BW){1'b0}}, beat};
            end
            default: ;
        endcase
    end

    assign mem_valid = mem_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign i_rvalid  = i_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign i_beat    = i_beat_q;
    assign i_done    = i_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic [1:0]  i_beat;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    mem_port_arbiter #(
        .WIDTH      (32),
        .LINE_WORDS (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .i_beat    (i_beat),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects IDLE and no competing data request; mem_ready held high throughout.
    task automatic do_refill(input logic [31:0] base, input logic [31:0] seed);
        logic [31:0] ea;
        logic [31:0] word;
        i_req     = 1'b1;
        i_addr    = base;
        mem_ready = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            ea   = base + b;
            word = seed + b;
            check("refill_addr", mem_addr, ea);
            check("refill_valid", {31'd0, mem_valid}, 32'd1);
            check("refill_we", {31'd0, mem_we}, 32'd0);
            mem_rdata = word;
            tick();
            check("refill_rvalid", {31'd0, i_rvalid}, 32'd1);
            check("refill_beat", {30'd0, i_beat}, b);
            check("refill_rdata", i_rdata, word);
            check("refill_done", {31'd0, i_done}, (b == 3) ? 32'd1 : 32'd0);
        end
        i_req     = 1'b0;
        mem_ready = 1'b0;
        tick();
        check("refill_idle_busy", {31'd0, busy}, 32'd0);
        check("refill_idle_rvalid", {31'd0, i_rvalid}, 32'd0);
        check("refill_idle_done", {31'd0, i_done}, 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_done", {30'd0, d_done, i_done}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Tie right after reset: data first, then the refill.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        i_req = 1'b1; i_addr = 32'h100;
        mem_ready = 1'b1; mem_rdata = 32'h11;
        tick();
        check("tie1_data_first", mem_addr, 32'h40);
        check("tie1_busy", {31'd0, busy}, 32'd1);
        tick();
        check("tie1_d_done", {31'd0, d_done}, 32'd1);
        check("tie1_d_rdata", d_rdata, 32'h11);
        d_req = 1'b0;
        do_refill(32'h100, 32'hA000_0000);

        // Second tie: last grant was INSTR, so data wins again.
        d_req = 1'b1; d_addr = 32'h44;
        i_req = 1'b1; i_addr = 32'h200;
        mem_ready = 1'b0;
        tick();
        check("tie2_data_first", mem_addr, 32'h44);
        check("tie2_we", {31'd0, mem_we}, 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h22;
        tick();
        check("tie2_d_done", {31'd0, d_done}, 32'd1);
        check("tie2_d_rdata", d_rdata, 32'h22);
        d_req = 1'b0;
        do_refill(32'h200, 32'hB000_0000);

        // Load completing on the second mem_valid cycle.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; mem_ready = 1'b0;
        tick();
        check("load_valid1", {31'd0, mem_valid}, 32'd1);
        check("load_addr", mem_addr, 32'h10);
        check("load_done_early", {31'd0, d_done}, 32'd0);
        tick();
        check("load_valid2", {31'd0, mem_valid}, 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        check("load_d_done", {31'd0, d_done}, 32'd1);
        check("load_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check("load_port_idle", {mem_addr[30:0], mem_valid}, 32'd0);
        d_req = 1'b0; mem_ready = 1'b0;
        tick();
        check("load_done_pulse", {31'd0, d_done}, 32'd0);

        // Store: latched fields ignore later input changes; d_rdata untouched.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
        tick();
        check("store_we", {31'd0, mem_we}, 32'd1);
        check("store_wdata", mem_wdata, 32'h1234_5678);
        d_wdata = 32'hFFFF_0000; d_addr = 32'h0;
        #1;
        check("store_wdata_held", mem_wdata, 32'h1234_5678);
        check("store_addr_held", mem_addr, 32'h20);
        mem_ready = 1'b1; mem_rdata = 32'hAAAA_5555;
        tick();
        check("store_d_done", {31'd0, d_done}, 32'd1);
        check("store_d_rdata_kept", d_rdata, 32'hDEAD_BEEF);
        check("store_port_we_idle", {31'd0, mem_we}, 32'd0);
        d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        tick();

        do_refill(32'h8, 32'hC000_0000);

        // Five-cycle stall at beat 2.
        i_req = 1'b1; i_addr = 32'h20; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            check("stall_addr", mem_addr, 32'h22);
            check("stall_valid", {31'd0, mem_valid}, 32'd1);
            check("stall_rvalid", {31'd0, i_rvalid}, 32'd0);
        end
        mem_ready = 1'b1; mem_rdata = 32'h77;
        tick();
        check("stall_resume_beat", {30'd0, i_beat}, 32'd2);
        check("stall_resume_done", {31'd0, i_done}, 32'd0);
        tick();
        check("stall_last_beat", {30'd0, i_beat}, 32'd3);
        check("stall_last_done", {31'd0, i_done}, 32'd1);
        i_req = 1'b0; mem_ready = 1'b0;
        tick();

        // Reset at beat 2 of a refill, request held through reset.
        i_req = 1'b1; i_addr = 32'h40; mem_ready = 1'b1;
        tick();
        tick();
        tick();
        check("mid_addr_beat2", mem_addr, 32'h42);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, mem_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_d_rdata", d_rdata, 32'd0);
        tick();
        check("mid_rst_no_done", {31'd0, i_done}, 32'd0);
        reset_n = 1'b1;
        do_refill(32'h40, 32'hD000_0000);

        do_refill(32'hFFFF_FFFC, 32'hE000_0000);
        do_refill(32'h8, 32'hF000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
